// File: rtl/pcie_tl_dll_tx_mux.sv
// Round-robin egress mux from TL TX sources onto the registered DLL TLP beat stream; grant held for a whole TLP.
// One cycle per beat source-to-DLL, one arbitration cycle between TLPs; granted ready = !o_dll_valid | i_dll_ready.
module pcie_tl_dll_tx_mux #(
    parameter int  NUM_SRC   = 4,
    parameter int  DW        = 32,
    parameter int  BUS_WIDTH = 8*DW,
    parameter int  CNT_WIDTH = 16,
    localparam int SEL_W     = $clog2(NUM_SRC)
) (
    input  logic                         i_clk,
    input  logic                         i_n_rst,
    input  logic [NUM_SRC-1:0]           i_src_valid,
    input  logic [NUM_SRC-1:0]           i_src_sop,
    input  logic [NUM_SRC-1:0]           i_src_eop,
    input  logic [3*NUM_SRC-1:0]         i_src_last_dw,
    input  logic [BUS_WIDTH*NUM_SRC-1:0] i_src_tlp,
    input  logic [NUM_SRC-1:0]           i_src_creds_ok,
    output logic [NUM_SRC-1:0]           o_src_ready,
    output logic                         o_dll_valid,
    output logic                         o_dll_sop,
    output logic                         o_dll_eop,
    output logic [2:0]                   o_dll_last_dw,
    output logic [BUS_WIDTH-1:0]         o_dll_tlp,
    input  logic                         i_dll_ready,
    output logic [SEL_W-1:0]             o_grant_src,
    output logic                         o_busy,
    output logic                         o_proto_err,
    output logic [CNT_WIDTH-1:0]         o_tlp_count
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t               state;
    logic [SEL_W-1:0]     rr_ptr;
    logic [SEL_W-1:0]     pick;
    logic [SEL_W:0]       scan;
    logic                 any_req;
    logic                 first_beat;
    logic                 out_free;
    logic                 accept;
    logic [NUM_SRC-1:0]   req;
    logic                 g_valid;
    logic                 g_sop;
    logic                 g_eop;
    logic [2:0]           g_last_dw;
    logic [BUS_WIDTH-1:0] g_tlp;

    assign req      = i_src_valid & i_src_sop & i_src_creds_ok;
    assign out_free = !o_dll_valid || i_dll_ready;
    assign accept   = (state == XFER) && g_valid && out_free;

    // First eligible source after the last grant, wrapping modulo NUM_SRC.
    always_comb begin
        any_req = 1'b0;
        pick    = '0;
        scan    = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            scan = {1'b0, rr_ptr} + (SEL_W+1)'(k);
            if (scan >= (SEL_W+1)'(NUM_SRC))
                scan = scan - (SEL_W+1)'(NUM_SRC);
            if (!any_req && req[scan[SEL_W-1:0]]) begin
                any_req = 1'b1;
                pick    = scan[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        g_valid     = 1'b0;
        g_sop       = 1'b0;
        g_eop       = 1'b0;
        g_last_dw   = '0;
        g_tlp       = '0;
        o_src_ready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (o_grant_src == SEL_W'(i)) begin
                g_valid        = i_src_valid[i];
                g_sop          = i_src_sop[i];
                g_eop          = i_src_eop[i];
                g_last_dw      = i_src_last_dw[i*3 +: 3];
                g_tlp          = i_src_tlp[i*BUS_WIDTH +: BUS_WIDTH];
                o_src_ready[i] = (state == XFER) && out_free;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            state         <= IDLE;
            rr_ptr        <= SEL_W'(NUM_SRC-1);
            o_grant_src   <= '0;
            o_busy        <= 1'b0;
            first_beat    <= 1'b0;
            o_proto_err   <= 1'b0;
            o_dll_valid   <= 1'b0;
            o_dll_sop     <= 1'b0;
            o_dll_eop     <= 1'b0;
            o_dll_last_dw <= '0;
            o_dll_tlp     <= '0;
            o_tlp_count   <= '0;
        end else begin
            o_proto_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        o_grant_src <= pick;
                        rr_ptr      <= pick;
                        o_busy      <= 1'b1;
                        first_beat  <= 1'b1;
                        state       <= XFER;
                    end
                end
                XFER: begin
                    if (accept) begin
                        first_beat  <= 1'b0;
                        // A sop inside a packet is flagged but still forwarded.
                        o_proto_err <= g_sop && !first_beat;
                        if (g_eop) begin
                            o_busy <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
            endcase

            if (accept) begin
                o_dll_valid   <= 1'b1;
                o_dll_sop     <= g_sop;
                o_dll_eop     <= g_eop;
                o_dll_last_dw <= g_last_dw;
                o_dll_tlp     <= g_tlp;
            end else if (i_dll_ready) begin
                o_dll_valid <= 1'b0;
            end

            if (o_dll_valid && i_dll_ready && o_dll_eop)
                o_tlp_count <= o_tlp_count + CNT_WIDTH'(1);
        end
    end

endmodule
